// File: rtl/ctrl_pipe_unit.sv
// RV32I pipelined control: decodes the ID opcode and carries the control bundle through EX/MEM/WB,
// with load-use/RAW bubbles, branch flush and memory stall. Define CTRL_FWD_EN to enable EX forwarding.
module ctrl_pipe_unit #(
  parameter int REG_AW         = 5,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic [7:0]        ex_ctrl,
  output logic [7:0]        mem_ctrl,
  output logic [7:0]        wb_ctrl,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              hazard_stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              illegal
);
  // Bundle bit positions: {rd_src, alu_in2_sel, pc_src, wb_sel, imm_sel, reg_w, mem_r, mem_w}
  localparam int REG_W = 2;
  localparam int MEM_R = 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [7:0]        dec_ctrl;
  logic              dec_legal, use_rs1, use_rs2;
  logic [7:0]        ex_ctrl_reg, mem_ctrl_reg, wb_ctrl_reg, ex_ctrl_next;
  logic              ex_valid_reg, mem_valid_reg, wb_valid_reg, ex_valid_next;
  logic [REG_AW-1:0] ex_rd_reg, mem_rd_reg, wb_rd_reg, ex_rd_next;
  logic              ex_src_hit, load_use, raw_dep;

  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (id_opcode)
      OP_R:      begin dec_ctrl = 8'b10000100; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IMM:    begin dec_ctrl = 8'b11001100; use_rs1 = 1'b1; end
      OP_LOAD:   begin dec_ctrl = 8'b01011110; use_rs1 = 1'b1; end
      OP_JALR:   begin dec_ctrl = 8'b01001100; use_rs1 = 1'b1; end
      OP_JAL:    dec_ctrl = 8'b01001100;
      OP_STORE:  begin dec_ctrl = 8'b11001001; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BRANCH: begin dec_ctrl = 8'b00101000; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_AUIPC:  dec_ctrl = 8'b00101100;
      OP_LUI:    dec_ctrl = 8'b01001100;
      default:   dec_legal = 1'b0;
    endcase
    if (id_rd == '0) dec_ctrl[REG_W] = 1'b0;
  end

  always_comb begin
    ex_src_hit = (use_rs1 && (ex_rd_reg == id_rs1)) || (use_rs2 && (ex_rd_reg == id_rs2));
    load_use   = id_valid && ex_valid_reg && ex_ctrl_reg[MEM_R] && (ex_rd_reg != '0) && ex_src_hit;
  end

`ifdef CTRL_FWD_EN
  assign raw_dep = 1'b0;
`else
  logic mem_src_hit;
  // Without forwarding, any pending write in EX or MEM must drain first; WB is bypassed by the RF.
  always_comb begin
    mem_src_hit = (use_rs1 && (mem_rd_reg == id_rs1)) || (use_rs2 && (mem_rd_reg == id_rs2));
    raw_dep = id_valid &&
              ((ex_valid_reg && ex_ctrl_reg[REG_W] && (ex_rd_reg != '0) && ex_src_hit) ||
               (mem_valid_reg && mem_ctrl_reg[REG_W] && (mem_rd_reg != '0) && mem_src_hit));
  end
`endif

  assign hazard_stall = rst_n && !mem_stall && !ex_flush && (load_use || raw_dep);
  assign illegal      = rst_n && id_valid && !dec_legal && !mem_stall && !ex_flush && !hazard_stall;

  always_comb begin
    ex_valid_next = 1'b0;
    ex_ctrl_next  = '0;
    ex_rd_next    = '0;
    if (!ex_flush && !hazard_stall && id_valid) begin
      if (dec_legal) begin
        ex_valid_next = 1'b1;
        ex_ctrl_next  = dec_ctrl;
        ex_rd_next    = id_rd;
      end else if (!NOP_ON_ILLEGAL) begin
        ex_valid_next = 1'b1;
        ex_rd_next    = id_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_reg   <= '0;
      mem_ctrl_reg  <= '0;
      wb_ctrl_reg   <= '0;
      ex_valid_reg  <= 1'b0;
      mem_valid_reg <= 1'b0;
      wb_valid_reg  <= 1'b0;
      ex_rd_reg     <= '0;
      mem_rd_reg    <= '0;
      wb_rd_reg     <= '0;
    end else if (!mem_stall) begin
      ex_ctrl_reg   <= ex_ctrl_next;
      ex_valid_reg  <= ex_valid_next;
      ex_rd_reg     <= ex_rd_next;
      mem_ctrl_reg  <= ex_ctrl_reg;
      mem_valid_reg <= ex_valid_reg;
      mem_rd_reg    <= ex_rd_reg;
      wb_ctrl_reg   <= mem_ctrl_reg;
      wb_valid_reg  <= mem_valid_reg;
      wb_rd_reg     <= mem_rd_reg;
    end
  end

`ifdef CTRL_FWD_EN
  logic [REG_AW-1:0] id_rs [2];
  assign id_rs[0] = id_rs1;
  assign id_rs[1] = id_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [REG_AW-1:0] rs_reg;
      logic [1:0]        sel;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rs_reg <= '0;
        else if (!mem_stall) rs_reg <= ex_valid_next ? id_rs[gi] : '0;
      end
      // MEM holds the younger result, so it wins over WB.
      always_comb begin
        sel = 2'b00;
        if (mem_valid_reg && mem_ctrl_reg[REG_W] && (mem_rd_reg != '0) && (mem_rd_reg == rs_reg))
          sel = 2'b01;
        else if (wb_valid_reg && wb_ctrl_reg[REG_W] && (wb_rd_reg != '0) && (wb_rd_reg == rs_reg))
          sel = 2'b10;
      end
    end
  endgenerate
  assign fwd_a = g_fwd[0].sel;
  assign fwd_b = g_fwd[1].sel;
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  assign ex_ctrl   = ex_ctrl_reg;
  assign mem_ctrl  = mem_ctrl_reg;
  assign wb_ctrl   = wb_ctrl_reg;
  assign ex_valid  = ex_valid_reg;
  assign mem_valid = mem_valid_reg;
  assign wb_valid  = wb_valid_reg;
  assign ex_rd     = ex_rd_reg;
  assign mem_rd    = mem_rd_reg;
  assign wb_rd     = wb_rd_reg;
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: expected stage contents are queued at drive time and
// retired into WB at each advancing edge. Works with and without CTRL_FWD_EN.
module tb_ctrl_pipe_unit;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic       v;
    logic [7:0] c;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_flush, mem_stall;
  logic [7:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic       ex_valid, mem_valid, wb_valid;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       hazard_stall, illegal;
  logic [1:0] fwd_a, fwd_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t sb_q[$];
  ent_t wb_exp;

  ctrl_pipe_unit #(.REG_AW(5), .NOP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_flush(ex_flush), .mem_stall(mem_stall),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .hazard_stall(hazard_stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void tb_decode(input logic [6:0] op, input logic [4:0] rd,
                                    output logic [7:0] c, output logic lg,
                                    output logic u1, output logic u2);
    c = '0; lg = 1'b1; u1 = 1'b0; u2 = 1'b0;
    case (op)
      OP_R:      begin c = 8'b10000100; u1 = 1'b1; u2 = 1'b1; end
      OP_IMM:    begin c = 8'b11001100; u1 = 1'b1; end
      OP_LOAD:   begin c = 8'b01011110; u1 = 1'b1; end
      OP_JALR:   begin c = 8'b01001100; u1 = 1'b1; end
      OP_JAL:    c = 8'b01001100;
      OP_STORE:  begin c = 8'b11001001; u1 = 1'b1; u2 = 1'b1; end
      OP_BRANCH: begin c = 8'b00101000; u1 = 1'b1; u2 = 1'b1; end
      OP_AUIPC:  c = 8'b00101100;
      OP_LUI:    c = 8'b01001100;
      default:   lg = 1'b0;
    endcase
    if (rd == 5'd0) c[2] = 1'b0;
  endfunction

  function automatic logic writes(input ent_t e, input logic [4:0] src);
    return e.v && e.c[2] && (e.rd != 5'd0) && (e.rd == src);
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] src, input ent_t m, input ent_t w);
    if (writes(m, src)) return 2'b01;
    if (writes(w, src)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [13:0] pk(input ent_t e);
    return {e.v, e.c, e.rd};
  endfunction

  task automatic sb_reset();
    sb_q.delete();
    wb_exp = '0;
    sb_q.push_back('0);
    sb_q.push_back('0);
  endtask

  task automatic step(input logic v, input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic flush, input logic stall, output logic haz);
    logic [7:0] c;
    logic       lg, u1, u2, lu, raw, ill;
    logic [1:0] fa, fb;
    ent_t       ex_e, mem_e, nx;
    @(negedge clk);
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    ex_flush = flush; mem_stall = stall;
    #1;
    tb_decode(op, rd, c, lg, u1, u2);
    mem_e = sb_q[0];
    ex_e  = sb_q[1];
    lu  = v && ex_e.v && ex_e.c[1] && (ex_e.rd != 5'd0) &&
          ((u1 && ex_e.rd == rs1) || (u2 && ex_e.rd == rs2));
    raw = 1'b0;
`ifdef CTRL_FWD_EN
    fa = fwd_model(ex_e.rs1, mem_e, wb_exp);
    fb = fwd_model(ex_e.rs2, mem_e, wb_exp);
`else
    raw = v && ((u1 && (writes(ex_e, rs1) || writes(mem_e, rs1))) ||
                (u2 && (writes(ex_e, rs2) || writes(mem_e, rs2))));
    fa = 2'b00;
    fb = 2'b00;
`endif
    haz = !stall && !flush && (lu || raw);
    ill = v && !lg && !stall && !flush && !haz;
    check_eq("hazard_stall", hazard_stall, haz);
    check_eq("illegal", illegal, ill);
    check_eq("fwd_a", fwd_a, fa);
    check_eq("fwd_b", fwd_b, fb);
    if (!stall) begin
      nx = '0;
      if (!flush && !haz && v && lg) begin
        nx.v = 1'b1; nx.c = c; nx.rd = rd; nx.rs1 = rs1; nx.rs2 = rs2;
      end
      sb_q.push_back(nx);
    end
    @(posedge clk);
    #1;
    if (!stall) wb_exp = sb_q.pop_front();
    check_eq("wb_stage", {wb_valid, wb_ctrl, wb_rd}, pk(wb_exp));
    check_eq("mem_stage", {mem_valid, mem_ctrl, mem_rd}, pk(sb_q[0]));
    check_eq("ex_stage", {ex_valid, ex_ctrl, ex_rd}, pk(sb_q[1]));
    $display("step v=%0b op=%b rd=%0d flush=%0b stall=%0b haz=%0b ex=%b/%0d wb=%b/%0d",
             v, op, rd, flush, stall, haz, ex_ctrl, ex_rd, wb_ctrl, wb_rd);
  endtask

  task automatic issue(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, output int stalls);
    logic h;
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, op, rs1, rs2, rd, 1'b0, 1'b0, h);
      if (!h) return;
      stalls++;
    end
    check_eq("issue_bound", h, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {ex_ctrl, mem_ctrl, wb_ctrl, ex_valid, mem_valid, wb_valid, ex_rd, mem_rd, wb_rd,
                   hazard_stall, fwd_a, fwd_b, illegal}, 64'd0);
  endtask

  initial begin
    int         ns;
    logic       h;
    logic [6:0] ops [10];
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_JAL, OP_STORE, OP_BRANCH, OP_AUIPC, OP_LUI, OP_BAD};
    rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    ex_flush = 1'b0; mem_stall = 1'b0;
    sb_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset_state");
    #2 rst_n = 1'b1;

    // ADDI x1; ADD x2,x1,x1; SW x2
    issue(OP_IMM, 5'd0, 5'd0, 5'd1, ns);
    check_eq("addi_ex_ctrl", ex_ctrl, 8'b11001100);
    issue(OP_R, 5'd1, 5'd1, 5'd2, ns);
`ifdef CTRL_FWD_EN
    check_eq("add_fwd_a", fwd_a, 2'b01);
`else
    check_eq("add_stalls", ns, 2);
`endif
    check_eq("add_ex_ctrl", ex_ctrl, 8'b10000100);
    issue(OP_STORE, 5'd0, 5'd2, 5'd0, ns);
    check_eq("sw_ex_ctrl", ex_ctrl, 8'b11001001);

    // load-use: LW x5 then ADD x6,x5,x0
    issue(OP_LOAD, 5'd0, 5'd0, 5'd5, ns);
    issue(OP_R, 5'd5, 5'd0, 5'd6, ns);
`ifdef CTRL_FWD_EN
    check_eq("lu_stalls", ns, 1);
    check_eq("lu_fwd_a", fwd_a, 2'b10);
`else
    check_eq("lu_stalls", ns, 2);
`endif

    // flush overrides a load-use hazard and discards the ID instruction
    issue(OP_LOAD, 5'd0, 5'd0, 5'd7, ns);
    step(1'b1, OP_R, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, h);
    check_eq("flush_ex_valid", ex_valid, 1'b0);
    issue(OP_LUI, 5'd0, 5'd0, 5'd9, ns);

    // mem_stall for 3 cycles with LW in MEM
    issue(OP_LOAD, 5'd0, 5'd0, 5'd10, ns);
    issue(OP_IMM, 5'd0, 5'd0, 5'd11, ns);
    for (int i = 0; i < 3; i++) step(1'b1, OP_LUI, 5'd0, 5'd0, 5'd12, 1'b0, 1'b1, h);
    check_eq("stall_mem_is_lw", mem_ctrl, 8'b01011110);
    issue(OP_LUI, 5'd0, 5'd0, 5'd12, ns);

    // x0 destination and illegal opcode
    issue(OP_IMM, 5'd0, 5'd0, 5'd0, ns);
    check_eq("x0_reg_w", ex_ctrl[2], 1'b0);
    issue(OP_BAD, 5'd0, 5'd0, 5'd3, ns);
    check_eq("illegal_ex_valid", ex_valid, 1'b0);
    issue(OP_JAL, 5'd0, 5'd0, 5'd4, ns);

    // randomized traffic with flushes and stalls
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 7) != 0, ops[$urandom_range(0, 9)],
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, h);
    end

    // async reset with instructions in flight
    issue(OP_IMM, 5'd0, 5'd0, 5'd1, ns);
    issue(OP_IMM, 5'd0, 5'd0, 5'd2, ns);
    issue(OP_IMM, 5'd0, 5'd0, 5'd3, ns);
    @(negedge clk);
    id_valid = 1'b1; id_opcode = OP_LUI; id_rd = 5'd4; ex_flush = 1'b0; mem_stall = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    sb_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    issue(OP_IMM, 5'd0, 5'd0, 5'd4, ns);
    check_eq("post_reset_accept", {ex_valid, ex_rd}, {1'b1, 5'd4});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
